sc_stream_gen: RTL

SC_STREAM_GEN -- requirements
Module: sc_stream_gen

---
 rtl/sc_pkg.sv | 21 ++
 rtl/sc_rng.sv | 31 +++
 rtl/sc_stream_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing stream generator.
// Holds the FSM state type, frame/word sizes, LFSR seed and the BN-to-threshold helper.
package sc_pkg;

   localparam int SC_LEN    = 16;
   localparam int SC_W      = 4;
   localparam int NUM_LANES = 4;
   localparam logic [SC_W-1:0] SEED = 4'h1;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } sc_state_e;

   // Two's-complement x in -8..7 plus 8 is just the MSB inverted; kept 5 bits wide.
   function automatic logic [SC_W:0] bias(input logic [SC_W-1:0] x);
      return {1'b0, ~x[SC_W-1], x[SC_W-2:0]};
   endfunction

endpackage

// File: rtl/sc_rng.sv
// 4-bit de Bruijn sequence generator: an LFSR extended to also visit the all-zero state,
// so every value 0..15 appears exactly once per 16 enabled cycles.
module sc_rng
   import sc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            en,
   output logic [SC_W-1:0] value
);

   logic [SC_W-1:0] lfsr;
   logic [SC_W-1:0] lfsr_next;

   // The zero-detect term splices 0000 into the maximal-length cycle between 1000 and 0001.
   assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2] ^ (lfsr[2:0] == 3'b000)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else if (load) begin
         lfsr <= SEED;
      end else if (en) begin
         lfsr <= lfsr_next;
      end
   end

   assign value = lfsr;

endmodule

// File: rtl/sc_stream_gen.sv
// Converts four latched bipolar (BN) values into 16-cycle stochastic bitstreams, one lane per value,
// using a shared de Bruijn source rotated differently per lane to decorrelate the lanes.
module sc_stream_gen
   import sc_pkg::*;
(
   input  logic                           i_clk_sng,
   input  logic                           i_rst_sng,
   input  logic                           i_start_sng,
   input  logic                           i_stop_sng,
   input  logic [NUM_LANES-1:0][SC_W-1:0] i_x_sng,
   output logic                           o_busy,
   output logic [NUM_LANES-1:0]           o_sn_bit,
   output logic                           o_done
);

   sc_state_e                     state;
   sc_state_e                     state_next;
   logic                          load;
   logic [SC_W-1:0]               cnt;
   logic [NUM_LANES-1:0][SC_W-1:0] x_lat;
   logic [SC_W-1:0]               lfsr;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      load       = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start_sng && !i_stop_sng) begin
               state_next = STREAM;
               load       = 1'b1;
            end
         end
         STREAM: begin
            if (i_stop_sng) begin
               state_next = IDLE;
            end else if (cnt == SC_W'(SC_LEN - 1)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments with an asynchronous reset so a mid-frame reset takes effect at once.
   always_ff @(posedge i_clk_sng or negedge i_rst_sng) begin
      if (!i_rst_sng) begin
         state <= IDLE;
         cnt   <= '0;
         x_lat <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            x_lat <= i_x_sng;
         end
         if (state == STREAM && !i_stop_sng) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

   sc_rng u_rng (
      .clk   (i_clk_sng),
      .rst_n (i_rst_sng),
      .load  (load),
      .en    (state == STREAM),
      .value (lfsr)
   );

   assign o_busy = (state == STREAM);
   assign o_done = (state == DONE);

   // Outputs depend only on registered state, lfsr and latched x, never on the live inputs.
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [2*SC_W-1:0] dbl;
      logic [SC_W-1:0]   rand_k;

      assign dbl         = {lfsr, lfsr};
      assign rand_k      = dbl[2*SC_W-1-k -: SC_W];
      assign o_sn_bit[k] = o_busy && ({1'b0, rand_k} < bias(x_lat[k]));
   end

endmodule
